// File: rtl/alu_fwd_ctrl.sv
// Hazard/forwarding controller: EX/MEM destination tracking, ALU operand selects, decode stall.
// Build option: define ALU_FWD_EN for forwarding; otherwise dependents stall until producers leave MEM.
module alu_fwd_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_a_pc,
  input  logic             id_b_imm,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_reg_wen,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       a_sel,
  output logic [1:0]       b_sel,
  output logic             ex_busy,
  output logic [CNT_W-1:0] stall_count
);

  logic            r_ex_v, r_ex_wen, r_ex_load;
  logic [RA_W-1:0] r_ex_rd;
  logic            r_mem_v, r_mem_wen;
  logic [RA_W-1:0] r_mem_rd;

  logic w_ex_live, w_mem_live;
  logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;
  logic w_ex_hit, w_mem_hit, w_haz, w_accept;
  logic [1:0] w_a_sel, w_b_sel;

  // x0 is hardwired zero, so a write to it never produces a forwardable value.
  assign w_ex_live  = r_ex_v  & r_ex_wen  & (r_ex_rd  != '0);
  assign w_mem_live = r_mem_v & r_mem_wen & (r_mem_rd != '0);

  assign w_ex_m1  = id_use_rs1 & w_ex_live  & (r_ex_rd  == id_rs1);
  assign w_ex_m2  = id_use_rs2 & w_ex_live  & (r_ex_rd  == id_rs2);
  assign w_mem_m1 = id_use_rs1 & w_mem_live & (r_mem_rd == id_rs1);
  assign w_mem_m2 = id_use_rs2 & w_mem_live & (r_mem_rd == id_rs2);
  assign w_ex_hit  = w_ex_m1 | w_ex_m2;
  assign w_mem_hit = w_mem_m1 | w_mem_m2;

`ifdef ALU_FWD_EN
  assign w_haz   = w_ex_hit & r_ex_load;
  assign w_a_sel = id_a_pc  ? 2'b01 : (w_ex_m1 ? 2'b10 : (w_mem_m1 ? 2'b11 : 2'b00));
  assign w_b_sel = id_b_imm ? 2'b01 : (w_ex_m2 ? 2'b10 : (w_mem_m2 ? 2'b11 : 2'b00));
`else
  // Without a bypass network every in-flight dependence waits; load-use is just one case of it.
  assign w_haz   = (w_ex_hit & r_ex_load) | w_ex_hit | w_mem_hit;
  assign w_a_sel = id_a_pc  ? 2'b01 : 2'b00;
  assign w_b_sel = id_b_imm ? 2'b01 : 2'b00;
`endif

  assign stall    = ~rst & id_valid & ~flush & w_haz;
  assign w_accept = id_valid & ~stall & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_v      <= 1'b0;
      r_ex_wen    <= 1'b0;
      r_ex_load   <= 1'b0;
      r_ex_rd     <= '0;
      r_mem_v     <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_rd    <= '0;
      a_sel       <= 2'b00;
      b_sel       <= 2'b00;
      ex_busy     <= 1'b0;
      stall_count <= '0;
    end else begin
      r_mem_v   <= r_ex_v;
      r_mem_wen <= r_ex_wen;
      r_mem_rd  <= r_ex_rd;
      if (w_accept) begin
        r_ex_v    <= 1'b1;
        r_ex_wen  <= id_reg_wen;
        r_ex_load <= id_is_load;
        r_ex_rd   <= id_rd;
        a_sel     <= w_a_sel;
        b_sel     <= w_b_sel;
        ex_busy   <= 1'b1;
      end else begin
        r_ex_v    <= 1'b0;
        r_ex_wen  <= 1'b0;
        r_ex_load <= 1'b0;
        r_ex_rd   <= '0;
        a_sel     <= 2'b00;
        b_sel     <= 2'b00;
        ex_busy   <= 1'b0;
      end
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: doc/alu_fwd_ctrl.md
Name: alu_fwd_ctrl

Overview:
- Hazard and forwarding controller for the single-issue pipeline. It produces the ALU operand-select codes a_sel/b_sel and a decode-stage stall.
- It tracks destination-register info for the instructions in EX and MEM. Each decoded instruction reads the newest in-flight result for its sources, and a bubble is inserted on load-use.
- It sits between decode and the EX pipeline register. Its a_sel/b_sel outputs drive the ALU directly during EX.

Parameters:
- RA_W, 5, register-address width.
- CNT_W, 16, width of the stall-cycle statistics counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_rs1  in  RA_W  source register 1 address
- id_rs2  in  RA_W  source register 2 address
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_a_pc  in  1  operand A is pc
- id_b_imm  in  1  operand B is imm
- id_rd  in  RA_W  destination register address
- id_reg_wen  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- flush  in  1  kill the decode instruction (taken branch/jump)
- stall  out  1  combinational; hold fetch/decode this cycle
- a_sel  out  2  registered; 00 rs1, 01 pc, 10 next_rd (MEM result), 11 next_next_rd (WB value)
- b_sel  out  2  registered; 00 rs2, 01 imm, 10 next_rd, 11 next_next_rd
- ex_busy  out  1  registered; a valid instruction is in EX
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: ex_busy=0, a_sel=00, b_sel=00, stall_count=0. Both tracking entries are invalid. stall=0 while rst is high.
- Tracking entries: EX entry {v, rd, wen, load} and MEM entry {v, rd, wen}, updated every clock.
  - EX entry takes the decode instruction when accepted, otherwise a bubble (v=0).
  - MEM entry takes the old EX entry unconditionally.
- Accepted instruction: id_valid & ~stall & ~flush.
- Live writer: entry v & wen & rd!=0. Register x0 never matches.
- Hazard match on a source: use_rsN & live writer & rd==id_rsN.
- Forwarding for an accepted instruction: sel is computed at decode and registered, so it is valid during the instruction's EX cycle.
  - Match with the EX entry gives code 10 (it will be in MEM).
  - Else match with the MEM entry gives code 11 (it will be in WB).
  - Else 00. The EX-entry match wins when both match.
  - id_a_pc forces a_sel=01 and id_b_imm forces b_sel=01, overriding forwarding.
- Load-use: if id_valid & ~flush & the EX entry is a live load matching any used source, stall=1 for exactly one cycle.
  - A bubble enters EX and decode holds.
  - Next cycle the load sits in the MEM entry, so the match resolves to code 11.
- Bubble cycles: a_sel/b_sel go to 00 and ex_busy=0.
- Register-file write-then-read covers WB-to-decode; it is not tracked here.
- flush takes precedence over stall: stall=0 and a bubble enters EX.
- stall_count increments on every cycle with stall=1 and saturates at all-ones.
- Reset asserted mid-operation clears all entries immediately. No hazard survives reset.

Optional Feature:
- Macro: ALU_FWD_EN.
- Defined: forwarding as described above.
- Undefined: no forwarding. a_sel/b_sel are only 00/01 (01 when id_a_pc/id_b_imm).
  - stall=1 while any used source matches a live EX or MEM entry, regardless of load.
  - A dependent instruction waits until its producer has left MEM (up to 2 stall cycles).
  - stall_count still counts stall cycles.

Test Plan:
- Reset then idle. Required: all outputs 0, stall_count=0.
- add x5 followed by sub x6,x5,x7. Required: in sub's EX cycle a_sel=10, b_sel=00, no stall.
- add x5, nop, and x8,x9,x5. Required: b_sel=11 for the and; same rd in both entries gives 10 priority.
- lw x3 then add x4,x3,x3. Required: stall=1 for one cycle, bubble ex_busy=0, then a_sel=b_sel=11; stall_count=1.
- Write to x0 then a reader of x0. Required: no forwarding, no stall. id_a_pc=1 with a hazard on rs1 gives a_sel=01.
- flush coincident with a load-use hazard gives stall=0 and a bubble. With ALU_FWD_EN undefined, add x5 then a reader of x5 gives stall=1 for 2 cycles and sel=00.
